// File: rtl/m_dmem_arb_pkg.sv
// rtl/m_dmem_arb_pkg.sv - shared encodings for the data-memory arbiter
package m_dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/m_dmem_arb_if.sv
// rtl/m_dmem_arb_if.sv - requester and memory-side bus of the data-memory arbiter
interface m_dmem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          w_req0;
    logic          w_we0;
    logic [AW-1:0] w_addr0;
    logic [DW-1:0] w_wdata0;
    logic          w_gnt0;
    logic          w_rvalid0;
    logic [DW-1:0] w_rdata0;
    logic          w_stall0;

    logic          w_req1;
    logic          w_we1;
    logic [AW-1:0] w_addr1;
    logic [DW-1:0] w_wdata1;
    logic          w_gnt1;
    logic          w_rvalid1;
    logic [DW-1:0] w_rdata1;

    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [DW-1:0] w_mem_rdata;

    modport slave (
        input  w_req0, w_we0, w_addr0, w_wdata0,
        output w_gnt0, w_rvalid0, w_rdata0, w_stall0,
        input  w_req1, w_we1, w_addr1, w_wdata1,
        output w_gnt1, w_rvalid1, w_rdata1,
        output w_mem_en, w_mem_we, w_mem_addr, w_mem_wdata,
        input  w_mem_rdata
    );

    modport master (
        output w_req0, w_we0, w_addr0, w_wdata0,
        input  w_gnt0, w_rvalid0, w_rdata0, w_stall0,
        output w_req1, w_we1, w_addr1, w_wdata1,
        input  w_gnt1, w_rvalid1, w_rdata1,
        input  w_mem_en, w_mem_we, w_mem_addr, w_mem_wdata,
        output w_mem_rdata
    );

endinterface

// File: rtl/m_arb_pick.sv
// rtl/m_arb_pick.sv - combinational two-way picker, fixed-priority or round-robin
module m_arb_pick
    import m_dmem_arb_pkg::*;
#(
    parameter int CPU_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            // Round-robin hands a tie to whichever port was not served last.
            winner = (CPU_PRIO != 0) ? P_CPU : ~last_owner;
        end else begin
            winner = req1 ? P_DBG : P_CPU;
        end
    end

endmodule

// File: rtl/m_dmem_arb.sv
// rtl/m_dmem_arb.sv - serialises CPU and debug accesses onto one data-memory port
module m_dmem_arb
    import m_dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LATENCY  = 1,
    parameter int CPU_PRIO = 0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_dmem_arb_if.slave bus
);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_owner_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    rdata0_q;
    logic [DW-1:0]    rdata1_q;
    logic             pick_winner;
    logic             pick_valid;

    m_arb_pick #(.CPU_PRIO(CPU_PRIO)) u_pick (
        .req0       (bus.w_req0),
        .req1       (bus.w_req1),
        .last_owner (last_owner_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pick_valid) state_d = S_ISSUE;
            S_ISSUE: state_d = we_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so the requester may not be re-sampled mid-access.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            cnt_q        <= '0;
            owner_q      <= P_CPU;
            last_owner_q <= P_DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_q      <= pick_winner;
                        last_owner_q <= pick_winner;
                        we_q         <= (pick_winner == P_DBG) ? bus.w_we1    : bus.w_we0;
                        addr_q       <= (pick_winner == P_DBG) ? bus.w_addr1  : bus.w_addr0;
                        wdata_q      <= (pick_winner == P_DBG) ? bus.w_wdata1 : bus.w_wdata0;
                    end
                end
                S_ISSUE: begin
                    if (!we_q) cnt_q <= CNT_W'(LATENCY);
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (owner_q == P_DBG) rdata1_q <= bus.w_mem_rdata;
                        else                  rdata0_q <= bus.w_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.w_mem_en    = 1'b0;
        bus.w_mem_we    = 1'b0;
        bus.w_mem_addr  = '0;
        bus.w_mem_wdata = '0;
        bus.w_gnt0      = 1'b0;
        bus.w_gnt1      = 1'b0;
        bus.w_rvalid0   = 1'b0;
        bus.w_rvalid1   = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
                bus.w_mem_en    = 1'b1;
                bus.w_mem_we    = we_q;
                bus.w_mem_addr  = addr_q;
                bus.w_mem_wdata = wdata_q;
                bus.w_gnt0      = (owner_q == P_CPU);
                bus.w_gnt1      = (owner_q == P_DBG);
            end
            S_RESP: begin
                bus.w_rvalid0 = (owner_q == P_CPU);
                bus.w_rvalid1 = (owner_q == P_DBG);
            end
            default: ;
        endcase
    end

    // The core advances on a store's grant or a load's data return.
    assign bus.w_stall0 = bus.w_req0 & ~(bus.w_gnt0 & bus.w_we0) & ~bus.w_rvalid0;
    assign bus.w_rdata0 = rdata0_q;
    assign bus.w_rdata1 = rdata1_q;

endmodule

// File: tb/tb_m_dmem_arb.sv
// tb/tb_m_dmem_arb.sv - directed bench: inst0 LAT=1 RR, inst1 LAT=3 RR, inst2 LAT=1 CPU priority
module tb_m_dmem_arb;

    logic w_clk = 1'b0;
    logic w_rst_n;
    always #5 w_clk = ~w_clk;

    logic [31:0] mem_img [0:15];

    logic [2:0]        req0_v, we0_v, req1_v, we1_v;
    logic [2:0][31:0]  addr0_v, wdata0_v, addr1_v, wdata1_v;
    logic [2:0]        gnt0_v, rvalid0_v, stall0_v, gnt1_v, rvalid1_v;
    logic [2:0]        mem_en_v, mem_we_v;
    logic [2:0][31:0]  rdata0_v, rdata1_v, mem_addr_v, mem_wdata_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT  = (g == 1) ? 3 : 1;
        localparam int PRIO = (g == 2) ? 1 : 0;

        m_dmem_arb_if #(.AW(32), .DW(32)) bus ();

        m_dmem_arb #(.AW(32), .DW(32), .LATENCY(LAT), .CPU_PRIO(PRIO)) u_dut (
            .w_clk   (w_clk),
            .w_rst_n (w_rst_n),
            .bus     (bus)
        );

        assign bus.w_req0   = req0_v[g];
        assign bus.w_we0    = we0_v[g];
        assign bus.w_addr0  = addr0_v[g];
        assign bus.w_wdata0 = wdata0_v[g];
        assign bus.w_req1   = req1_v[g];
        assign bus.w_we1    = we1_v[g];
        assign bus.w_addr1  = addr1_v[g];
        assign bus.w_wdata1 = wdata1_v[g];

        assign gnt0_v[g]      = bus.w_gnt0;
        assign rvalid0_v[g]   = bus.w_rvalid0;
        assign rdata0_v[g]    = bus.w_rdata0;
        assign stall0_v[g]    = bus.w_stall0;
        assign gnt1_v[g]      = bus.w_gnt1;
        assign rvalid1_v[g]   = bus.w_rvalid1;
        assign rdata1_v[g]    = bus.w_rdata1;
        assign mem_en_v[g]    = bus.w_mem_en;
        assign mem_we_v[g]    = bus.w_mem_we;
        assign mem_addr_v[g]  = bus.w_mem_addr;
        assign mem_wdata_v[g] = bus.w_mem_wdata;

        // Read-only memory image; data is driven only in the cycle LAT cycles after the strobe.
        logic [31:0] rd_pend = 32'h0;
        logic [3:0]  rd_cnt  = 4'd0;
        always @(posedge w_clk) begin
            if (bus.w_mem_en && !bus.w_mem_we) begin
                rd_pend <= mem_img[bus.w_mem_addr[5:2]];
                rd_cnt  <= 4'(LAT);
            end else if (rd_cnt != 4'd0) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
        end
        assign bus.w_mem_rdata = (rd_cnt == 4'd1) ? rd_pend : 32'h0;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge w_clk);
        #2;
    endtask

    task automatic rd_txn(input int g, input int p, input logic [31:0] addr,
                          input logic [31:0] exp_d, input int lat, input string tag);
        int gc, rc, bad_stall;
        gc = 0; rc = 0; bad_stall = 0;
        if (p == 0) begin req0_v[g] = 1'b1; we0_v[g] = 1'b0; addr0_v[g] = addr; end
        else        begin req1_v[g] = 1'b1; we1_v[g] = 1'b0; addr1_v[g] = addr; end
        for (int k = 1; k <= 30 && rc == 0; k++) begin
            tick(1);
            if (((p == 0) ? gnt0_v[g] : gnt1_v[g]) && gc == 0) gc = k;
            if ((p == 0) ? rvalid0_v[g] : rvalid1_v[g]) rc = k;
            else if (p == 0 && !stall0_v[g]) bad_stall++;
        end
        check_eq({tag, "_gnt_cycle"}, 32'(gc), 32'd1);
        check_eq({tag, "_rvalid_cycle"}, 32'(rc), 32'(lat + 2));
        check_eq({tag, "_rdata"}, (p == 0) ? rdata0_v[g] : rdata1_v[g], exp_d);
        if (p == 0) begin
            check_eq({tag, "_stall_hold"}, 32'(bad_stall), 32'd0);
            check_eq({tag, "_stall_at_rvalid"}, 32'(stall0_v[g]), 32'd0);
        end
        tick(1);
        if (p == 0) req0_v[g] = 1'b0; else req1_v[g] = 1'b0;
        tick(1);
    endtask

    initial begin
        int order0 [3];
        int order2 [3];
        int n0, n2, dbg2, rv_seen;

        for (int i = 0; i < 16; i++) mem_img[i] = 32'h0;
        mem_img[1]  = 32'h11110001;
        mem_img[2]  = 32'h22220002;
        mem_img[3]  = 32'hCAFE0003;
        mem_img[8]  = 32'h12345678;
        mem_img[12] = 32'h0000AAAA;
        mem_img[13] = 32'h00005555;

        req0_v = '0; we0_v = '0; addr0_v = '0; wdata0_v = '0;
        req1_v = '0; we1_v = '0; addr1_v = '0; wdata1_v = '0;
        w_rst_n = 1'b0;
        tick(3);
        check_eq("rst_gnt0",   32'(gnt0_v[0]),   32'd0);
        check_eq("rst_gnt1",   32'(gnt1_v[0]),   32'd0);
        check_eq("rst_rvalid", 32'(rvalid0_v[0] | rvalid1_v[0]), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en_v[0]), 32'd0);
        check_eq("rst_rdata0", rdata0_v[0], 32'h0);
        check_eq("rst_rdata1", rdata1_v[0], 32'h0);
        w_rst_n = 1'b1;
        tick(1);

        // CPU store on inst0
        req0_v[0] = 1'b1; we0_v[0] = 1'b1; addr0_v[0] = 32'h10; wdata0_v[0] = 32'hDEADBEEF;
        #1;
        check_eq("st_stall_pre", 32'(stall0_v[0]), 32'd1);
        tick(1);
        check_eq("st_gnt0",      32'(gnt0_v[0]),    32'd1);
        check_eq("st_mem_en",    32'(mem_en_v[0]),  32'd1);
        check_eq("st_mem_we",    32'(mem_we_v[0]),  32'd1);
        check_eq("st_mem_addr",  mem_addr_v[0],     32'h10);
        check_eq("st_mem_wdata", mem_wdata_v[0],    32'hDEADBEEF);
        check_eq("st_stall_gnt", 32'(stall0_v[0]),  32'd0);
        check_eq("st_rvalid",    32'(rvalid0_v[0]), 32'd0);
        tick(1);
        req0_v[0] = 1'b0; we0_v[0] = 1'b0;
        check_eq("st_gnt0_after",   32'(gnt0_v[0]),   32'd0);
        check_eq("st_mem_en_after", 32'(mem_en_v[0]), 32'd0);
        tick(1);
        check_eq("st_no_rvalid", 32'(rvalid0_v[0]), 32'd0);

        // CPU loads with latency 1 and 3
        rd_txn(0, 0, 32'h20, 32'h12345678, 1, "ld_l1");
        rd_txn(1, 0, 32'h20, 32'h12345678, 3, "ld_l3");

        // Arbitration from reset: inst0 round-robin, inst2 CPU priority
        w_rst_n = 1'b0;
        tick(2);
        w_rst_n = 1'b1;
        for (int g = 0; g < 3; g += 2) begin
            req0_v[g] = 1'b1; we0_v[g] = 1'b0; addr0_v[g] = 32'h04;
            req1_v[g] = 1'b1; we1_v[g] = 1'b0; addr1_v[g] = 32'h08;
        end
        n0 = 0; n2 = 0; dbg2 = 0;
        for (int k = 0; k < 40 && (n0 < 3 || n2 < 3); k++) begin
            tick(1);
            if (n0 < 3 && gnt0_v[0]) begin order0[n0] = 0; n0++; end
            else if (n0 < 3 && gnt1_v[0]) begin order0[n0] = 1; n0++; end
            if (n2 < 3 && gnt0_v[2]) begin order2[n2] = 0; n2++; end
            else if (n2 < 3 && gnt1_v[2]) begin order2[n2] = 1; n2++; end
            if (gnt1_v[2]) dbg2++;
        end
        check_eq("rr_count", 32'(n0), 32'd3);
        check_eq("rr_first",  32'(order0[0]), 32'd0);
        check_eq("rr_second", 32'(order0[1]), 32'd1);
        check_eq("rr_third",  32'(order0[2]), 32'd0);
        check_eq("rr_dbg_rdata", rdata1_v[0], 32'h22220002);
        check_eq("prio_count", 32'(n2), 32'd3);
        check_eq("prio_order", 32'(order2[0] + order2[1] + order2[2]), 32'd0);
        check_eq("prio_dbg_gnts", 32'(dbg2), 32'd0);
        check_eq("prio_rdata0", rdata0_v[2], 32'h11110001);
        req0_v = '0; req1_v = '0;
        tick(5);

        // DBG write in ISSUE while the CPU raises a load
        req1_v[0] = 1'b1; we1_v[0] = 1'b1; addr1_v[0] = 32'h40; wdata1_v[0] = 32'h0BADF00D;
        tick(1);
        check_eq("dw_gnt1",     32'(gnt1_v[0]),   32'd1);
        check_eq("dw_mem_addr", mem_addr_v[0],    32'h40);
        req0_v[0] = 1'b1; we0_v[0] = 1'b0; addr0_v[0] = 32'h20;
        #1;
        check_eq("dw_gnt0_issue",  32'(gnt0_v[0]),   32'd0);
        check_eq("dw_stall_issue", 32'(stall0_v[0]), 32'd1);
        tick(1);
        check_eq("dw_no_dup_gnt1", 32'(gnt1_v[0]),   32'd0);
        check_eq("dw_gnt0_idle",   32'(gnt0_v[0]),   32'd0);
        check_eq("dw_stall_idle",  32'(stall0_v[0]), 32'd1);
        req1_v[0] = 1'b0; we1_v[0] = 1'b0;
        tick(1);
        check_eq("dw_cpu_gnt0",  32'(gnt0_v[0]),   32'd1);
        check_eq("dw_cpu_gnt1",  32'(gnt1_v[0]),   32'd0);
        check_eq("dw_cpu_stall", 32'(stall0_v[0]), 32'd1);
        tick(1);
        check_eq("dw_wait_stall",  32'(stall0_v[0]), 32'd1);
        check_eq("dw_wait_mem_en", 32'(mem_en_v[0]), 32'd0);
        tick(1);
        check_eq("dw_rvalid0", 32'(rvalid0_v[0]), 32'd1);
        check_eq("dw_rdata0",  rdata0_v[0],       32'h12345678);
        check_eq("dw_stall_rv", 32'(stall0_v[0]), 32'd0);
        tick(1);
        req0_v[0] = 1'b0;
        tick(1);

        // Reset during WAIT of a DBG read on inst1 (latency 3)
        rd_txn(1, 1, 32'h30, 32'h0000AAAA, 3, "pre_rst");
        req1_v[1] = 1'b1; we1_v[1] = 1'b0; addr1_v[1] = 32'h0C;
        tick(1);
        check_eq("mr_gnt1", 32'(gnt1_v[1]), 32'd1);
        tick(1);
        check_eq("mr_wait_mem_en",   32'(mem_en_v[1]), 32'd0);
        check_eq("mr_wait_mem_addr", mem_addr_v[1],    32'h0);
        w_rst_n = 1'b0;
        tick(1);
        check_eq("mr_gnt",    32'(gnt0_v[1] | gnt1_v[1]),     32'd0);
        check_eq("mr_rvalid", 32'(rvalid0_v[1] | rvalid1_v[1]), 32'd0);
        check_eq("mr_mem_en", 32'(mem_en_v[1]), 32'd0);
        check_eq("mr_rdata1", rdata1_v[1], 32'h0);
        w_rst_n = 1'b1; req1_v[1] = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (rvalid1_v[1] || gnt1_v[1]) rv_seen++;
        end
        check_eq("mr_no_late_rvalid", 32'(rv_seen), 32'd0);
        check_eq("mr_rdata1_after",   rdata1_v[1],  32'h0);

        // Interleaved reads keep per-port data separate
        rd_txn(0, 1, 32'h30, 32'h0000AAAA, 1, "il_dbg");
        rd_txn(0, 0, 32'h34, 32'h00005555, 1, "il_cpu");
        check_eq("il_rdata1_kept", rdata1_v[0], 32'h0000AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
